// File: rtl/mpsoc_axi4_pkg.sv
// Shared AXI4 encodings, FSM state type and helpers
// for the memory-to-AXI4 master bridge.
package mpsoc_axi4_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [3:0] CACHE_DEFAULT = 4'b0010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_WRESP,
        ST_READ,
        ST_RRESP
    } state_t;

    // AxSIZE encoding for a beat of the given byte count
    function automatic logic [2:0] axi_size(input int bytes);
        logic [2:0] s;
        s = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if ((1 << i) == bytes) begin
                s = 3'(i);
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/mpsoc_axi4_mem_master.sv
// Memory request interface to AXI4 master bridge.
// Single-beat, one transaction outstanding.
module mpsoc_axi4_mem_master
    import mpsoc_axi4_pkg::*;
#(
    parameter int AXI_ID_WIDTH   = 10,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
    parameter int AXI_USER_WIDTH = 10,
    parameter int AXI_ID         = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_i,
    input  logic                      we_i,
    input  logic [AXI_ADDR_WIDTH-1:0] addr_i,
    input  logic [AXI_STRB_WIDTH-1:0] be_i,
    input  logic [AXI_DATA_WIDTH-1:0] data_i,
    output logic                      gnt_o,
    output logic                      rvalid_o,
    output logic [AXI_DATA_WIDTH-1:0] data_o,
    output logic                      err_o,
    output logic [AXI_ID_WIDTH-1:0]   axi_aw_id,
    output logic [AXI_ADDR_WIDTH-1:0] axi_aw_addr,
    output logic [7:0]                axi_aw_len,
    output logic [2:0]                axi_aw_size,
    output logic [1:0]                axi_aw_burst,
    output logic                      axi_aw_lock,
    output logic [3:0]                axi_aw_cache,
    output logic [2:0]                axi_aw_prot,
    output logic [3:0]                axi_aw_qos,
    output logic [3:0]                axi_aw_region,
    output logic [AXI_USER_WIDTH-1:0] axi_aw_user,
    output logic                      axi_aw_valid,
    input  logic                      axi_aw_ready,
    output logic [AXI_DATA_WIDTH-1:0] axi_w_data,
    output logic [AXI_STRB_WIDTH-1:0] axi_w_strb,
    output logic                      axi_w_last,
    output logic [AXI_USER_WIDTH-1:0] axi_w_user,
    output logic                      axi_w_valid,
    input  logic                      axi_w_ready,
    input  logic [AXI_ID_WIDTH-1:0]   axi_b_id,
    input  logic [1:0]                axi_b_resp,
    input  logic [AXI_USER_WIDTH-1:0] axi_b_user,
    input  logic                      axi_b_valid,
    output logic                      axi_b_ready,
    output logic [AXI_ID_WIDTH-1:0]   axi_ar_id,
    output logic [AXI_ADDR_WIDTH-1:0] axi_ar_addr,
    output logic [7:0]                axi_ar_len,
    output logic [2:0]                axi_ar_size,
    output logic [1:0]                axi_ar_burst,
    output logic                      axi_ar_lock,
    output logic [3:0]                axi_ar_cache,
    output logic [2:0]                axi_ar_prot,
    output logic [3:0]                axi_ar_qos,
    output logic [3:0]                axi_ar_region,
    output logic [AXI_USER_WIDTH-1:0] axi_ar_user,
    output logic                      axi_ar_valid,
    input  logic                      axi_ar_ready,
    input  logic [AXI_ID_WIDTH-1:0]   axi_r_id,
    input  logic [AXI_DATA_WIDTH-1:0] axi_r_data,
    input  logic [1:0]                axi_r_resp,
    input  logic                      axi_r_last,
    input  logic [AXI_USER_WIDTH-1:0] axi_r_user,
    input  logic                      axi_r_valid,
    output logic                      axi_r_ready
);

    localparam logic [AXI_ID_WIDTH-1:0] LP_ID = AXI_ID_WIDTH'(AXI_ID);
    localparam logic [2:0] LP_SIZE = axi_size(AXI_STRB_WIDTH);

    state_t r_state;
    state_t w_state_nxt;

    logic [AXI_ADDR_WIDTH-1:0] r_addr;
    logic [AXI_STRB_WIDTH-1:0] r_be;
    logic [AXI_DATA_WIDTH-1:0] r_wdata;
    logic [AXI_DATA_WIDTH-1:0] r_rdata;
    logic                      r_aw_done;
    logic                      r_w_done;
    logic                      r_rvalid;
    logic                      r_err;

    logic w_grant;
    logic w_b_hs;
    logic w_r_hs;
    logic w_unused;

    assign w_unused = ^{axi_b_user, axi_r_user};

    // Grant is suppressed during the completion pulse so a new
    // request is taken only in the cycle after rvalid_o.
    assign w_grant = req_i & (r_state == ST_IDLE) & ~r_rvalid;
    assign w_b_hs  = (r_state == ST_WRESP) & axi_b_valid;
    assign w_r_hs  = (r_state == ST_RRESP) & axi_r_valid;

    assign gnt_o    = w_grant;
    assign rvalid_o = r_rvalid;
    assign err_o    = r_err;
    assign data_o   = r_rdata;

    assign axi_aw_id     = LP_ID;
    assign axi_aw_addr   = r_addr;
    assign axi_aw_len    = 8'd0;
    assign axi_aw_size   = LP_SIZE;
    assign axi_aw_burst  = BURST_INCR;
    assign axi_aw_lock   = 1'b0;
    assign axi_aw_cache  = CACHE_DEFAULT;
    assign axi_aw_prot   = 3'b000;
    assign axi_aw_qos    = 4'd0;
    assign axi_aw_region = 4'd0;
    assign axi_aw_user   = '0;
    assign axi_w_data    = r_wdata;
    assign axi_w_strb    = r_be;
    assign axi_w_last    = 1'b1;
    assign axi_w_user    = '0;
    assign axi_ar_id     = LP_ID;
    assign axi_ar_addr   = r_addr;
    assign axi_ar_len    = 8'd0;
    assign axi_ar_size   = LP_SIZE;
    assign axi_ar_burst  = BURST_INCR;
    assign axi_ar_lock   = 1'b0;
    assign axi_ar_cache  = CACHE_DEFAULT;
    assign axi_ar_prot   = 3'b000;
    assign axi_ar_qos    = 4'd0;
    assign axi_ar_region = 4'd0;
    assign axi_ar_user   = '0;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and channel valids/readies, all decoded from registers
    always_comb begin
        w_state_nxt  = r_state;
        axi_aw_valid = 1'b0;
        axi_w_valid  = 1'b0;
        axi_b_ready  = 1'b0;
        axi_ar_valid = 1'b0;
        axi_r_ready  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_state_nxt = we_i ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                axi_aw_valid = ~r_aw_done;
                axi_w_valid  = ~r_w_done;
                if ((r_aw_done | axi_aw_ready) &&
                    (r_w_done | axi_w_ready)) begin
                    w_state_nxt = ST_WRESP;
                end
            end
            ST_WRESP: begin
                axi_b_ready = 1'b1;
                if (axi_b_valid) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_READ: begin
                axi_ar_valid = 1'b1;
                if (axi_ar_ready) begin
                    w_state_nxt = ST_RRESP;
                end
            end
            ST_RRESP: begin
                axi_r_ready = 1'b1;
                if (axi_r_valid) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Command buffer, handshake flags and completion registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_addr    <= '0;
            r_be      <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_rvalid  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if (w_grant) begin
                r_addr    <= addr_i;
                r_be      <= be_i;
                r_wdata   <= data_i;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end else if (r_state == ST_WRITE) begin
                r_aw_done <= r_aw_done | axi_aw_ready;
                r_w_done  <= r_w_done | axi_w_ready;
            end
            r_rvalid <= w_b_hs | w_r_hs;
            r_err    <= 1'b0;
            if (w_b_hs) begin
                r_err <= (axi_b_resp != RESP_OKAY) |
                         (axi_b_id != LP_ID);
            end
            if (w_r_hs) begin
                r_rdata <= axi_r_data;
                r_err   <= (axi_r_resp != RESP_OKAY) |
                           ~axi_r_last |
                           (axi_r_id != LP_ID);
            end
        end
    end

endmodule
